// File: rtl/ulpi_pkg.sv
// Shared ULPI link types: command codes, link FSM states, queue entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ulpi_pkg;

    typedef enum logic [1:0] {
        NOOP = 2'b00,
        TX   = 2'b01,
        REGW = 2'b10,
        REGR = 2'b11
    } cmd_code_e;

    typedef enum logic [2:0] {
        IDLE,
        TX_CMD,
        TX_DATA,
        TX_STP,
        RD_TURN,
        RD_DATA,
        RD_END
    } link_state_e;

    // Byte driven on the bus during the stop cycle
    localparam logic [7:0] STP_DATA = 8'h00;

    // One queued command: the command byte plus its write data
    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] wdata;
    } cmd_entry_t;

    // Only register write and register read reach the bus
    function automatic logic code_supported(input logic [1:0] code);
        return code[1];
    endfunction

endpackage

// File: rtl/ulpi_link_engine_if.sv
// ULPI bus bundle between link (master) and PHY (slave).
// Latency: none, plain wires.
// Backpressure: carried by ulpi_nxt / ulpi_dir from the PHY.
interface ulpi_link_engine_if;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic [7:0] ulpi_data_in;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe;
    logic       ulpi_stp;

    modport master (
        input  ulpi_dir,
        input  ulpi_nxt,
        input  ulpi_data_in,
        output ulpi_data_out,
        output ulpi_data_oe,
        output ulpi_stp
    );

    modport slave (
        output ulpi_dir,
        output ulpi_nxt,
        output ulpi_data_in,
        input  ulpi_data_out,
        input  ulpi_data_oe,
        input  ulpi_stp
    );
endinterface

// File: rtl/ulpi_cmd_fifo.sv
// Command queue: power-of-2 depth circular buffer with full/empty flags.
// Latency: pushed entry is visible at the head one cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module ulpi_cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    // A pop frees a slot in the same cycle, so a full queue still takes a push then
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_dat = mem[rd_ptr];

    // Storage array, written at the tail
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ulpi_link_engine.sv
// ULPI link engine: queued register read/write commands out, RX data/RX CMD in.
// Latency: RX byte -> data 1 cycle; queued command reaches the bus 2 cycles after strobe.
// Backpressure: cmd_busy when queue full; bus transfers stall on ulpi_nxt, abort on ulpi_dir.
module ulpi_link_engine
    import ulpi_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RXCMD_EVT = 1
) (
    input  logic                clk,
    input  logic                reset,
    ulpi_link_engine_if.master  ulpi,
    output logic [7:0]          data,
    output logic                data_valid,
    output logic [7:0]          rx_cmd,
    output logic                rx_cmd_evt,
    input  logic [7:0]          cmd,
    input  logic [7:0]          cmd_wdata,
    input  logic                cmd_strobe,
    output logic                cmd_busy,
    output logic                cmd_error,
    output logic [7:0]          reg_rdata,
    output logic                reg_rdata_valid
);
    link_state_e state;
    link_state_e state_nxt;
    cmd_entry_t  head;
    cmd_entry_t  cur;
    logic [15:0] head_raw;
    logic        dir_q;
    logic        turnaround;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        take_cmd;
    logic        drop_cmd;
    logic        rx_byte;
    logic        rx_load;
    logic        oe_c;
    logic        stp_c;
    logic [7:0]  dout_c;

    assign turnaround = (ulpi.ulpi_dir != dir_q);
    assign head       = cmd_entry_t'(head_raw);
    assign cmd_busy   = fifo_full;
    assign rx_byte    = !turnaround && ulpi.ulpi_dir && ulpi.ulpi_nxt;
    assign rx_load    = !turnaround && ulpi.ulpi_dir && !ulpi.ulpi_nxt && (state != RD_DATA);

    ulpi_cmd_fifo #(
        .WIDTH (16),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (cmd_strobe),
        .push_dat ({cmd, cmd_wdata}),
        .pop      (fifo_pop),
        .pop_dat  (head_raw),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // State register plus the registered bus direction used for turnaround detection
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            dir_q <= 1'b0;
        end else begin
            state <= state_nxt;
            dir_q <= ulpi.ulpi_dir;
        end
    end

    // Next state; the PHY taking the bus before accepting the command parks us in TX_CMD to reissue
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        take_cmd  = 1'b0;
        drop_cmd  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !ulpi.ulpi_dir) begin
                    fifo_pop = 1'b1;
                    if (code_supported(head.cmd[7:6])) begin
                        take_cmd  = 1'b1;
                        state_nxt = TX_CMD;
                    end else begin
                        drop_cmd = 1'b1;
                    end
                end
            end
            TX_CMD: begin
                if (!turnaround && !ulpi.ulpi_dir && ulpi.ulpi_nxt)
                    state_nxt = (cmd_code_e'(cur.cmd[7:6]) == REGW) ? TX_DATA : RD_TURN;
            end
            TX_DATA: begin
                if (ulpi.ulpi_dir)
                    state_nxt = TX_CMD;
                else if (!turnaround && ulpi.ulpi_nxt)
                    state_nxt = TX_STP;
            end
            TX_STP:  state_nxt = IDLE;
            RD_TURN: if (ulpi.ulpi_dir) state_nxt = RD_DATA;
            RD_DATA: state_nxt = RD_END;
            RD_END:  if (!ulpi.ulpi_dir) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs; the link never drives during a turnaround or while the PHY owns the bus
    always_comb begin
        oe_c   = 1'b0;
        stp_c  = 1'b0;
        dout_c = 8'h00;
        case (state)
            TX_CMD:  dout_c = cur.cmd;
            TX_DATA: dout_c = cur.wdata;
            TX_STP: begin
                dout_c = STP_DATA;
                stp_c  = 1'b1;
            end
            default: dout_c = 8'h00;
        endcase
        if (!ulpi.ulpi_dir && !turnaround &&
            (state == TX_CMD || state == TX_DATA || state == TX_STP))
            oe_c = 1'b1;
    end

    assign ulpi.ulpi_data_out = dout_c;
    assign ulpi.ulpi_data_oe  = oe_c;
    assign ulpi.ulpi_stp      = stp_c;

    // Head entry is held here for the whole transfer, including reissue after an abort
    always_ff @(posedge clk) begin
        if (reset)         cur <= '0;
        else if (take_cmd) cur <= head;
    end

    // Receive path: packet bytes and RX CMD bytes
    always_ff @(posedge clk) begin
        if (reset) begin
            data       <= 8'h00;
            data_valid <= 1'b0;
            rx_cmd     <= 8'h00;
            rx_cmd_evt <= 1'b0;
        end else begin
            data_valid <= rx_byte;
            if (rx_byte) data <= ulpi.ulpi_data_in;
            rx_cmd_evt <= (RXCMD_EVT != 0) && rx_load && (ulpi.ulpi_data_in != rx_cmd);
            if (rx_load) rx_cmd <= ulpi.ulpi_data_in;
        end
    end

    // Command completion pulses: register read result and dropped-command error
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_rdata       <= 8'h00;
            reg_rdata_valid <= 1'b0;
            cmd_error       <= 1'b0;
        end else begin
            reg_rdata_valid <= (state == RD_DATA);
            if (state == RD_DATA) reg_rdata <= ulpi.ulpi_data_in;
            cmd_error <= drop_cmd;
        end
    end
endmodule
